// File: rtl/hex_word_streamer.sv
// Streams a DATA_WIDTH-bit word as ASCII hex, most-significant nibble first,
// one character per valid/ready transfer, with an optional CR/LF terminator.
module hex_word_streamer #(
  parameter int DATA_WIDTH = 64,
  parameter bit LOWERCASE  = 1'b0,
  parameter bit TERMINATE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_char,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if (((DATA_WIDTH % 4) != 0) || (DATA_WIDTH < 4)) begin : g_bad_width
    $error("hex_word_streamer: DATA_WIDTH must be a multiple of 4 and at least 4");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // out_valid never drops and out_char never changes until its transfer.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIGITS = 2'd1,
    S_CR     = 2'd2,
    S_LF     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            char_q, char_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] base;
    if (n < 4'd10) begin
      base = 8'h30;
    end else begin
      // Offset so that n=10 lands on 'A' (0x41) or 'a' (0x61).
      base = LOWERCASE ? 8'h57 : 8'h37;
    end
    return base + {4'h0, n};
  endfunction

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          char_d  = hex_char(in_data[DATA_WIDTH-1 -: 4]);
          valid_d = 1'b1;
          cnt_d   = CNT_W'(NIBBLES - 1);
          state_d = S_DIGITS;
        end
      end
      S_DIGITS: begin
        if (valid_q && out_ready) begin
          if (cnt_q != '0) begin
            shift_d = shift_q << 4;
            char_d  = hex_char(shift_d[DATA_WIDTH-1 -: 4]);
            cnt_d   = cnt_q - 1'b1;
          end else if (TERMINATE) begin
            char_d  = 8'h0D;
            state_d = S_CR;
          end else begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_CR: begin
        if (valid_q && out_ready) begin
          char_d  = 8'h0A;
          state_d = S_LF;
        end
      end
      S_LF: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_char  = char_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hex_word_streamer.sv
// Directed bench for hex_word_streamer: three configurations (16-bit upper
// with CR/LF, 64-bit lower with CR/LF, 4-bit without terminator).
module tb_hex_word_streamer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // 16-bit, uppercase, terminated
  logic [15:0] a_in_data;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [7:0]  a_out_char;
  logic [1:0]  a_dbg;
  // 64-bit, lowercase, terminated
  logic [63:0] b_in_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [7:0]  b_out_char;
  logic [1:0]  b_dbg;
  // 4-bit, no terminator
  logic [3:0]  c_in_data;
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [7:0]  c_out_char;
  logic [1:0]  c_dbg;

  hex_word_streamer #(.DATA_WIDTH(16), .LOWERCASE(1'b0), .TERMINATE(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_char(a_out_char), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .busy(a_busy), .dbg_state(a_dbg)
  );

  hex_word_streamer #(.DATA_WIDTH(64), .LOWERCASE(1'b1), .TERMINATE(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_char(b_out_char), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .busy(b_busy), .dbg_state(b_dbg)
  );

  hex_word_streamer #(.DATA_WIDTH(4), .LOWERCASE(1'b0), .TERMINATE(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_char(c_out_char), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .busy(c_busy), .dbg_state(c_dbg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard for instance A
  logic [7:0] exp_q[$];
  logic [7:0] a_got_q[$];
  logic       a_stall_prev = 1'b0;
  logic [7:0] a_char_prev  = 8'h00;

  always @(posedge clk) begin
    a_stall_prev <= a_out_valid && !a_out_ready && rst_n;
    a_char_prev  <= a_out_char;
    if (a_out_valid && a_out_ready) a_got_q.push_back(a_out_char);
  end

  always @(negedge clk) begin
    if (a_stall_prev && rst_n) begin
      check("hold_valid", a_out_valid, 1);
      check("hold_char", a_out_char, a_char_prev);
    end
  end

  task automatic a_send(input logic [15:0] w);
    int cyc = 0;
    @(negedge clk);
    while (!a_in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("send_ready", a_in_ready, 1);
    a_in_data  = w;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_data  = ~w;
  endtask

  task automatic a_drain(input int n, input bit rand_rdy);
    int cyc = 0;
    logic [7:0] e, g;
    while ((a_got_q.size() < n || a_busy) && cyc < 300) begin
      @(negedge clk);
      a_out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
    end
    a_out_ready = 1'b1;
    check("drain_timeout", 64'(cyc < 300), 1);
    repeat (4) @(negedge clk);
    check("char_count", a_got_q.size(), n);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (a_got_q.size() > 0) ? a_got_q.pop_front() : 8'hxx;
      check("stream_char", g, e);
    end
    a_got_q.delete();
  endtask

  logic [7:0] t1 [6]  = '{8'h31, 8'h41, 8'h33, 8'h46, 8'h0D, 8'h0A};
  logic [7:0] t2 [18] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                          8'h38, 8'h39, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66,
                          8'h0D, 8'h0A};
  logic [7:0] t4 [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A, 8'h00,
                          8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};

  initial begin
    rst_n = 1'b0;
    a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_valid = 1'b0; c_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_char", a_out_char, 8'h00);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_ready", a_in_ready, 1);
    check("rst_b_valid", b_out_valid, 0);
    check("rst_c_ready", c_in_ready, 1);

    // 16'h1A3F, cycle-exact, in_data changed right after acceptance
    a_in_data  = 16'h1A3F;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_data  = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      check("t1_valid", a_out_valid, 1);
      check("t1_char", a_out_char, t1[i]);
      check("t1_in_ready", a_in_ready, 0);
      check("t1_busy", a_busy, 1);
      @(negedge clk);
    end
    check("t1_end_valid", a_out_valid, 0);
    check("t1_end_ready", a_in_ready, 1);
    check("t1_end_busy", a_busy, 0);
    a_got_q.delete();

    // 64-bit lowercase covering all nibble values
    b_in_data  = 64'h0123456789ABCDEF;
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    b_in_data  = '0;
    for (int i = 0; i < 18; i++) begin
      check("t2_valid", b_out_valid, 1);
      check("t2_char", b_out_char, t2[i]);
      @(negedge clk);
    end
    check("t2_end_valid", b_out_valid, 0);
    check("t2_end_ready", b_in_ready, 1);

    // Backpressure on 16'hBEEF
    a_out_ready = 1'b0;
    a_send(16'hBEEF);
    exp_q.push_back(8'h42); exp_q.push_back(8'h45); exp_q.push_back(8'h45);
    exp_q.push_back(8'h46); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    a_drain(6, 1'b1);

    // in_valid held high while busy; back-to-back with one idle cycle
    @(negedge clk);
    a_in_data  = 16'h1234;
    a_in_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      check("t4_valid", a_out_valid, 64'(i != 6));
      if (i != 6) check("t4_char", a_out_char, t4[i]);
      check("t4_in_ready", a_in_ready, 64'(i == 6));
      if (i == 6) a_in_data = 16'h5678;
      else if (i < 6) a_in_data = 16'($urandom);
      if (i == 7) a_in_valid = 1'b0;
    end
    @(negedge clk);
    check("t4_end_valid", a_out_valid, 0);
    check("t4_end_ready", a_in_ready, 1);
    a_got_q.delete();

    // 4-bit word without terminator
    c_in_data  = 4'h9;
    c_in_valid = 1'b1;
    @(negedge clk);
    c_in_valid = 1'b0;
    check("t5_valid", c_out_valid, 1);
    check("t5_char", c_out_char, 8'h39);
    check("t5_in_ready", c_in_ready, 0);
    @(negedge clk);
    check("t5_end_valid", c_out_valid, 0);
    check("t5_end_ready", c_in_ready, 1);
    check("t5_end_busy", c_busy, 0);
    @(negedge clk);
    check("t5_no_term", c_out_valid, 0);

    // Asynchronous reset mid-word, then a clean word
    a_send(16'h1A3F);
    @(negedge clk);
    @(negedge clk);
    check("t6_pre_char", a_out_char, 8'h33);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", a_out_valid, 0);
    check("t6_rst_char", a_out_char, 8'h00);
    check("t6_rst_busy", a_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_rel_ready", a_in_ready, 1);
    a_got_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h30);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    a_send(16'h0000);
    a_drain(6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: bench did not complete, time %0t limit 200000", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
